// File: rtl/frame_reader.sv
// Raster-order frame buffer reader: walks the BRAM read port and streams the
// frame out as AXI4-Stream video (tuser = start of frame, tlast = end of line).
module frame_reader #(
   parameter int WIDTH     = 640,
   parameter int HEIGHT    = 480,
   parameter int BIT_WIDTH = 8,
   parameter int AW        = $clog2(WIDTH*HEIGHT)+1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 enb,
   output logic [AW-1:0]        addrb,
   input  logic [BIT_WIDTH-1:0] dob,
   output logic [BIT_WIDTH-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tuser,
   output logic                 m_axis_tlast
);

   localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH*HEIGHT-1);
   localparam logic [XW-1:0] LAST_X    = XW'(WIDTH-1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state, state_next;
   logic [AW-1:0] addr;
   logic [XW-1:0] x;
   logic          pend, pend_sof, pend_eol;
   logic          load, issue, last_beat;

   // pend marks a pixel sitting on dob that has not yet moved to the output
   // register; a new read is only issued when that slot is free or draining.
   always_comb begin
      load       = pend & (!m_axis_tvalid | m_axis_tready);
      issue      = (state == RUN) & (!pend | load);
      last_beat  = (state == DRAIN) & m_axis_tvalid & m_axis_tready & !pend;
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (issue && addr == LAST_ADDR) state_next = DRAIN;
         DRAIN:   if (last_beat) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign enb   = issue;
   assign addrb = addr;
   assign busy  = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         frame_done <= 1'b0;
         addr       <= '0;
         x          <= '0;
         pend       <= 1'b0;
         pend_sof   <= 1'b0;
         pend_eol   <= 1'b0;
      end else begin
         state      <= state_next;
         frame_done <= last_beat;
         pend       <= issue | (pend & !load);
         if (state == IDLE && start) begin
            addr <= '0;
            x    <= '0;
         end else if (issue) begin
            addr     <= (addr == LAST_ADDR) ? '0 : addr + AW'(1);
            x        <= (x == LAST_X) ? '0 : x + XW'(1);
            pend_sof <= (addr == '0);
            pend_eol <= (x == LAST_X);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else if (load) begin
         m_axis_tdata  <= dob;
         m_axis_tvalid <= 1'b1;
         m_axis_tuser  <= pend_sof;
         m_axis_tlast  <= pend_eol;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule
